// File: rtl/systolic_result_streamer_pkg.sv
// Shared types and sizing for the systolic result streamer.
package systolic_result_streamer_pkg;

  localparam int N      = 4;
  localparam int ELEM_W = 16;
  localparam int BEATS  = 16;
  localparam int IDX_W  = $clog2(BEATS);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/systolic_result_streamer.sv
// Serialises a completed 4x4 product matrix into 16 ready/valid beats,
// scanning row-major or column-major, and flags results that arrive while
// a previous matrix is still being streamed.
module systolic_result_streamer
  import systolic_result_streamer_pkg::*;
#(
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic                                 i_clk,
  input  logic                                 i_arst,
  input  logic                                 i_validResult,
  input  logic [N-1:0][N-1:0][ELEM_W-1:0]      i_c,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [ELEM_W-1:0]                    o_data,
  output logic [1:0]                           o_row,
  output logic [1:0]                           o_col,
  output logic                                 o_last,
  output logic                                 o_busy,
  output logic                                 o_overrun,
  input  logic                                 i_clearOverrun
);

  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(BEATS - 1);

  state_e                            state_q;
  logic [IDX_W-1:0]                  k_q;
  logic [N-1:0][N-1:0][ELEM_W-1:0]   hold_q;
  logic                              overrun_q;
  logic                              overrun_d;

  logic                              xfer;
  logic                              lastXfer;
  logic                              overrunSet;
  logic [1:0]                        rowIdx;
  logic [1:0]                        colIdx;

  // Handshake decode: o_valid is purely the registered state, so i_ready
  // never reaches o_valid combinationally.
  assign xfer       = (state_q == STREAM) && i_ready;
  assign lastXfer   = xfer && (k_q == LAST_K);
  assign overrunSet = i_validResult && (state_q == STREAM) && !lastXfer;

  // Beat index to matrix coordinate; the upper half of k selects the outer
  // scan dimension.
  assign rowIdx = COL_MAJOR ? k_q[1:0] : k_q[IDX_W-1:IDX_W/2];
  assign colIdx = COL_MAJOR ? k_q[IDX_W-1:IDX_W/2] : k_q[1:0];

  // Sticky overrun flag: a fresh drop takes priority over a clear request.
  always_comb begin
    overrun_d = overrunSet | (overrun_q & ~i_clearOverrun);
  end

  // Streaming FSM with hold register and beat index.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      hold_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      case (state_q)
        IDLE: begin
          if (i_validResult) begin
            hold_q  <= i_c;
            k_q     <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (lastXfer) begin
            k_q <= '0;
            if (i_validResult) begin
              hold_q <= i_c;
            end else begin
              state_q <= IDLE;
            end
          end else if (xfer) begin
            k_q <= k_q + IDX_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          k_q     <= '0;
        end
      endcase
    end
  end

  assign o_valid   = (state_q == STREAM);
  assign o_busy    = (state_q == STREAM);
  assign o_last    = (state_q == STREAM) && (k_q == LAST_K);
  assign o_data    = hold_q[rowIdx][colIdx];
  assign o_row     = rowIdx;
  assign o_col     = colIdx;
  assign o_overrun = overrun_q;

endmodule

// File: doc/systolic_result_streamer.md
SYSTOLIC_RESULT_STREAMER -- requirements
Module: systolic_result_streamer

Interface
REQ-001 The block SHALL have parameter COL_MAJOR, default 0: 0 = row-major scan order, 1 = column-major scan order.
REQ-002 i_clk  input  1  clock; all state updates on the rising edge.
REQ-003 i_arst  input  1  reset, asynchronous, active-high.
REQ-004 i_validResult  input  1  one-cycle pulse: i_c holds a completed 4x4 product.
REQ-005 i_c  input  [3:0][3:0][15:0]  product matrix, indexed [row][col].
REQ-006 o_valid  output  1  o_data holds a valid beat.
REQ-007 i_ready  input  1  downstream accepts the current beat.
REQ-008 o_data  output  16  current matrix element.
REQ-009 o_row  output  2  row index of o_data.
REQ-010 o_col  output  2  column index of o_data.
REQ-011 o_last  output  1  high on the 16th beat of a matrix.
REQ-012 o_busy  output  1  high while a matrix is held and not fully streamed.
REQ-013 o_overrun  output  1  sticky flag: a result was dropped.
REQ-014 i_clearOverrun  input  1  clears o_overrun.

Function
REQ-015 The FSM SHALL have two states, IDLE and STREAM; o_busy SHALL equal (state == STREAM).
REQ-016 IDLE with i_validResult=1: capture all 256 bits of i_c into a hold register, set beat index to 0, enter STREAM; o_valid SHALL be high on the next cycle (latency 1).
REQ-017 A beat SHALL transfer on any cycle where o_valid && i_ready.
REQ-018 While o_valid && !i_ready, o_data, o_row, o_col and o_last SHALL hold stable.
REQ-019 The 4-bit beat index k SHALL increment by 1 per transfer; COL_MAJOR=0 gives row=k[3:2], col=k[1:0]; COL_MAJOR=1 gives col=k[3:2], row=k[1:0].
REQ-020 o_data SHALL equal hold[o_row][o_col]; o_last SHALL equal (k == 15).
REQ-021 A transfer with k == 15 SHALL return the FSM to IDLE with o_valid=0 on the next cycle, unless REQ-022 applies.
REQ-022 i_validResult coinciding with the k == 15 transfer SHALL capture the new matrix, reset k to 0 and stay in STREAM, with no bubble and no overrun.
REQ-023 i_validResult in STREAM at any other time SHALL be dropped, leave the hold register and k unchanged, and set o_overrun on the next cycle.
REQ-024 i_clearOverrun SHALL clear o_overrun on the next cycle; a simultaneous new overrun SHALL win (flag stays 1).
REQ-025 i_validResult in IDLE SHALL never set o_overrun.
REQ-026 Element values SHALL pass through unmodified: no truncation, sign handling or arithmetic.

Reset
REQ-027 On i_arst: state=IDLE, k=0, hold register=0, o_valid=0, o_last=0, o_busy=0, o_overrun=0, o_data=0, o_row=0, o_col=0.
REQ-028 Assertion of i_arst mid-stream SHALL abort the matrix; no beats SHALL resume after release.
REQ-029 The first i_validResult after reset release SHALL be accepted normally.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, STREAM), N=4, ELEM_W=16 and BEATS=16; the block SHALL import it.
REQ-031 The block SHALL be a single module with no sub-module; the index-to-row/col mapping SHALL be inline combinational logic.
REQ-032 Outputs SHALL be driven from registers or from the hold register through a 16:1 mux on k, with no combinational path from i_ready to o_valid.

Verification
REQ-033 i_c[r][c] = 16*r + c, pulse, i_ready=1 constantly -> 16 consecutive beats with o_data 0,1,2,3,16,...,51; o_last only on 51; o_busy low on the cycle after.
REQ-034 COL_MAJOR=1 with the same matrix -> beats 0,16,32,48,1,...,51; o_row/o_col match.
REQ-035 i_ready toggled by random 50% backpressure -> no element lost or duplicated; outputs stable during every stall.
REQ-036 Second pulse at beat 5 -> o_overrun=1 and the stream continues with the original matrix; i_clearOverrun -> o_overrun=0.
REQ-037 Second pulse on the o_last transfer (value 0xFFFF everywhere) -> next cycle o_valid=1 and o_data=0xFFFF, row 0, col 0, o_overrun=0.
REQ-038 i_arst asserted at beat 7 -> all outputs 0 at once; after release o_valid stays 0 until the next pulse.
